// File: rtl/fc_pkg.sv
// -----------------------------------------------------------------------------
// fc_pkg
// Shared definitions for the fully-connected layer address sequencer:
//   - fc_state_e   : sequencer FSM states (IDLE, RUN)
//   - FC_IN_DEPTH  : default number of input features per neuron
//   - FC_HOLD      : default enabled cycles per input address
//   - FC_OUT_DEPTH : default number of output neurons per layer
//   - fc_width()   : counter width for a given depth, never below 1 bit
// -----------------------------------------------------------------------------
package fc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fc_state_e;

  localparam int FC_IN_DEPTH  = 10;
  localparam int FC_HOLD      = 28;
  localparam int FC_OUT_DEPTH = 4;

  // A depth of 1 still needs a 1-bit register to keep port widths legal.
  function automatic int fc_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fc_wrap_cnt.sv
// -----------------------------------------------------------------------------
// fc_wrap_cnt
// Modulo-MODULUS up counter used as one stage of the sequencer cascade.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-low reset, clears the count
//   clr_i  in   synchronous clear, wins over en_i
//   en_i   in   advance by one, wrapping MODULUS-1 -> 0
//   cnt_o  out  current count (W bits)
//   tc_o   out  terminal-count flag, high while cnt_o == MODULUS-1
// -----------------------------------------------------------------------------
module fc_wrap_cnt
  import fc_pkg::*;
#(
  parameter int MODULUS = 2,
  parameter int W       = fc_width(MODULUS)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear first, then wrap-or-increment when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST);

endmodule

// File: rtl/fc_addr_seq.sv
// -----------------------------------------------------------------------------
// fc_addr_seq
// Address/timing sequencer for the fully-connected layer. Holds each input
// feature address for HOLD_CYCLES enabled cycles, steps through IN_DEPTH
// inputs per output neuron and OUT_DEPTH neurons per layer.
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-low reset
//   start       in   launch request, only looked at in IDLE
//   fully_en    in   advance enable; low freezes all counters
//   abort       in   (FC_SEQ_ABORT_EN builds only) drop the layer, back to IDLE
//   in_addr     out  input-feature address, one cycle behind the counter
//   out_addr    out  output-neuron address, aligned with in_addr
//   acc_clr     out  one-cycle pulse after the last cycle of each hold window
//   layer_done  out  one-cycle pulse after the final window of the layer
//   busy        out  high while the FSM is in RUN
// Build option:
//   FC_SEQ_ABORT_EN  adds the abort input; without it only reset ends a layer.
// -----------------------------------------------------------------------------
module fc_addr_seq
  import fc_pkg::*;
#(
  parameter int IN_DEPTH    = FC_IN_DEPTH,
  parameter int HOLD_CYCLES = FC_HOLD,
  parameter int OUT_DEPTH   = FC_OUT_DEPTH,
  parameter int CONTINUOUS  = 0,
  parameter int IN_AW       = fc_width(IN_DEPTH),
  parameter int OUT_AW      = fc_width(OUT_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              fully_en,
`ifdef FC_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic [IN_AW-1:0]  in_addr,
  output logic [OUT_AW-1:0] out_addr,
  output logic              acc_clr,
  output logic              layer_done,
  output logic              busy
);

  localparam int HOLD_W = fc_width(HOLD_CYCLES);

  fc_state_e         state_q;
  logic              busy_q;
  logic              acc_clr_q;
  logic              layer_done_q;
  logic [IN_AW-1:0]  in_addr_q;
  logic [OUT_AW-1:0] out_addr_q;

  logic [HOLD_W-1:0] hold_cnt;
  logic [IN_AW-1:0]  in_cnt;
  logic [OUT_AW-1:0] out_cnt;
  logic              hold_tc;
  logic              in_tc;
  logic              out_tc;
  logic              hold_cnt_unused;

  logic              abort_w;
  logic              run_w;
  logic              clr_w;
  logic              hold_en;
  logic              in_en;
  logic              out_en;

`ifdef FC_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Abort outranks fully_en, so it both clears and blocks the cascade.
  assign run_w   = (state_q == RUN);
  assign clr_w   = run_w & abort_w;
  assign hold_en = run_w & fully_en & ~abort_w;
  assign in_en   = hold_en & hold_tc;
  assign out_en  = in_en & in_tc;

  // The hold count is only consumed through its terminal flag.
  assign hold_cnt_unused = ^hold_cnt;

  fc_wrap_cnt #(
    .MODULUS (HOLD_CYCLES),
    .W       (HOLD_W)
  ) u_hold_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (clr_w),
    .en_i  (hold_en),
    .cnt_o (hold_cnt),
    .tc_o  (hold_tc)
  );

  fc_wrap_cnt #(
    .MODULUS (IN_DEPTH),
    .W       (IN_AW)
  ) u_in_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (clr_w),
    .en_i  (in_en),
    .cnt_o (in_cnt),
    .tc_o  (in_tc)
  );

  fc_wrap_cnt #(
    .MODULUS (OUT_DEPTH),
    .W       (OUT_AW)
  ) u_out_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (clr_w),
    .en_i  (out_en),
    .cnt_o (out_cnt),
    .tc_o  (out_tc)
  );

  // FSM with registered outputs. At the final window all three counters wrap
  // to zero on their own, so returning to IDLE needs no extra clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      acc_clr_q    <= 1'b0;
      layer_done_q <= 1'b0;
      in_addr_q    <= '0;
      out_addr_q   <= '0;
    end else begin
      in_addr_q    <= in_cnt;
      out_addr_q   <= out_cnt;
      acc_clr_q    <= 1'b0;
      layer_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (abort_w) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (fully_en && hold_tc) begin
            acc_clr_q <= 1'b1;
            if (in_tc && out_tc) begin
              layer_done_q <= 1'b1;
              if (CONTINUOUS == 0) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_addr    = in_addr_q;
  assign out_addr   = out_addr_q;
  assign acc_clr    = acc_clr_q;
  assign layer_done = layer_done_q;
  assign busy       = busy_q;

endmodule
